// File: rtl/rotation_sensor_conditioner_pkg.sv
// Shared types and defaults for the rotation sensor conditioner.
// Holds FSM state encodings, default parameter values and the common increment helper.
package rotation_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    ROT_IDLE = 2'd0,
    ROT_SYNC = 2'd1,
    ROT_RUN  = 2'd2
  } rot_state_e;

  localparam int DEF_WIDTH       = 26;
  localparam int DEF_DEBOUNCE    = 16;
  localparam int DEF_MIN_PERIOD  = 1000;
  localparam int DEF_STALL_LIMIT = 50_000_000;

  // All counters share this one adder; callers cast to their own width.
  function automatic logic [31:0] plus1(input logic [31:0] a);
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/rotation_sensor_conditioner_if.sv
// Sensor-side bundle: raw index input plus the conditioned outputs.
// The slave modport is the conditioner; the master modport is the sensor/renderer side.
interface rotation_sensor_conditioner_if
  import rotation_sensor_conditioner_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             sensor_raw;
  logic             clock_cycle;
  logic             rotating;
  logic [WIDTH-1:0] period;
  logic [7:0]       glitch_cnt;

  modport master (output sensor_raw, input clock_cycle, rotating, period, glitch_cnt);
  modport slave  (input sensor_raw, output clock_cycle, rotating, period, glitch_cnt);
endinterface

// File: rtl/rotation_sensor_conditioner_level_debouncer.sv
// 2-FF synchroniser plus run-length debounce filter.
// out follows in only after DEBOUNCE consecutive disagreeing synced samples.
module level_debouncer
  import rotation_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);
  localparam int RW = $clog2(DEBOUNCE);

  logic          s1_q, s2_q, filt_q;
  logic [RW-1:0] run_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
      if (s2_q != filt_q) begin
        // The DEBOUNCE-th disagreeing sample flips the filter.
        if (run_q == RW'(DEBOUNCE - 1)) begin
          filt_q <= s2_q;
          run_q  <= '0;
        end else begin
          run_q  <= RW'(plus1(32'(run_q)));
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign out = filt_q;
endmodule

// File: rtl/rotation_sensor_conditioner.sv
// Turns the raw once-per-revolution index sensor into a clean clock_cycle pulse with
// period, rotating and lockout-glitch reporting. Define ROT_STALL_DETECT_EN for stall detection.
module rotation_sensor_conditioner
  import rotation_sensor_conditioner_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  rotation_sensor_conditioner_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

  if (DEBOUNCE < 2 || MIN_PERIOD < 2 || (STALL_LIMIT >> WIDTH) != 0) begin : g_bad_params
    $error("rotation_sensor_conditioner: illegal parameter combination");
  end

  rot_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             pulse_q, pulse_d, rot_q, rot_d;
  logic             sensor_n, filt, filt_q, ev_q, accept, stall;

  // Static inversion only, so normalising before the synchroniser adds no glitch path.
  assign sensor_n = bus.sensor_raw ^ ACTIVE_LOW;

  level_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clock (clock),
    .reset (reset),
    .in    (sensor_n),
    .out   (filt)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : WIDTH'(plus1(32'(cnt_q)));
  assign accept  = ev_q && (state_q == ROT_IDLE || cnt_inc >= MIN_P);

`ifdef ROT_STALL_DETECT_EN
  localparam logic [WIDTH-1:0] STALL_P = WIDTH'(STALL_LIMIT);
  assign stall = (state_q != ROT_IDLE) && (cnt_inc == STALL_P);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ROT_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      glitch_q <= '0;
      pulse_q  <= 1'b0;
      rot_q    <= 1'b0;
      filt_q   <= 1'b0;
      ev_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      glitch_q <= glitch_d;
      pulse_q  <= pulse_d;
      rot_q    <= rot_d;
      filt_q   <= filt;
      ev_q     <= filt & ~filt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROT_IDLE: if (ev_q) state_d = ROT_SYNC;
      ROT_SYNC,
      ROT_RUN: begin
        if (accept)     state_d = ROT_RUN;
        else if (stall) state_d = ROT_IDLE;
      end
      default: state_d = ROT_IDLE;
    endcase
  end

  // An accepted event outranks a stall landing on the same cycle.
  always_comb begin
    cnt_d    = cnt_inc;
    period_d = period_q;
    glitch_d = glitch_q;
    pulse_d  = 1'b0;
    rot_d    = rot_q;
    if (accept) begin
      cnt_d = '0;
      if (state_q != ROT_IDLE) begin
        pulse_d  = 1'b1;
        period_d = cnt_inc;
        rot_d    = 1'b1;
      end
    end else if (ev_q) begin
      if (!(&glitch_q)) glitch_d = 8'(plus1(32'(glitch_q)));
    end else if (stall) begin
      rot_d    = 1'b0;
      period_d = '0;
    end
  end

  assign bus.clock_cycle = pulse_q;
  assign bus.rotating    = rot_q;
  assign bus.period      = period_q;
  assign bus.glitch_cnt  = glitch_q;
endmodule
